// File: rtl/fir_control_unit.sv
// Control unit for a streaming FIR datapath: coefficient load sequencing, sample
// pacing against a result-FIFO credit budget, and drain/shutdown handling.
module fir_control_unit #(
   parameter int MAX_TAPS  = 16,
   parameter int LATENCY   = 1,
   parameter int OUT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cfg_tap_count,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   output logic        cfg_busy,
   output logic        cfg_error,
   input  logic        s_coeff_tvalid,
   output logic        s_coeff_tready,
   input  logic [31:0] s_coeff_tdata,
   input  logic        s_data_tvalid,
   output logic        s_data_tready,
   input  logic [31:0] s_data_tdata,
   output logic        m_out_tvalid,
   input  logic        m_out_tready,
   output logic [31:0] m_out_tdata,
   output logic        fir_rstn,
   output logic [31:0] tap_count,
   output logic        input_data_valid,
   output logic [31:0] input_data,
   output logic        coeff_data_valid,
   output logic [31:0] coeff_data,
   output logic        compute,
   input  logic [31:0] output_data,
   input  logic        output_data_valid,
   input  logic        coefficient_loading_complete
);

   localparam int AW = $clog2(OUT_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(LATENCY + 2);
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(OUT_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD_COEFF, RUN, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [31:0]     coeff_cnt;
   logic [WW-1:0]   wait_cnt;
   logic [CW-1:0]   inflight, fifo_count;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [31:0]     fifo_mem [OUT_DEPTH];
   logic            rst_q;
   logic            cfg_ok, credit_ok, coeff_hs, data_hs, pop, fifo_full, push_ok;
   logic            unused_inputs;

   // Sequencing runs off our own coefficient count, not the datapath's done flag.
   assign unused_inputs = coefficient_loading_complete;

   assign cfg_ok    = (cfg_tap_count != 32'd0) && (cfg_tap_count <= 32'(MAX_TAPS));
   assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) <= CREDIT_MAX;

   always_comb begin
      state_nxt      = state;
      s_coeff_tready = 1'b0;
      s_data_tready  = 1'b0;
      case (state)
         IDLE:       if (cfg_start && cfg_ok) state_nxt = CLEAR;
         CLEAR:      state_nxt = LOAD_COEFF;
         LOAD_COEFF: begin
            s_coeff_tready = 1'b1;
            if (s_coeff_tvalid && coeff_cnt == tap_count - 32'd1) state_nxt = RUN;
         end
         RUN: begin
            s_data_tready = (wait_cnt == '0) && credit_ok && !cfg_stop;
            if (cfg_stop) state_nxt = DRAIN;
         end
         DRAIN:      if (wait_cnt == '0 && inflight == '0 && fifo_count == '0) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   assign coeff_hs         = s_coeff_tvalid && s_coeff_tready;
   assign data_hs          = s_data_tvalid && s_data_tready;
   assign coeff_data_valid = coeff_hs;
   assign coeff_data       = coeff_hs ? s_coeff_tdata : 32'd0;
   assign input_data_valid = data_hs;
   assign input_data       = data_hs ? s_data_tdata : 32'd0;
   assign compute          = data_hs;

   assign fifo_full    = fifo_count == CW'(OUT_DEPTH);
   assign m_out_tvalid = fifo_count != '0;
   assign m_out_tdata  = m_out_tvalid ? fifo_mem[rd_ptr] : 32'd0;
   assign pop          = m_out_tvalid && m_out_tready;
   assign push_ok      = output_data_valid && (!fifo_full || pop);

   assign cfg_busy = state != IDLE;
   // Registered reset copy keeps the datapath in reset one cycle past rst.
   assign fir_rstn = !rst_q && (state != CLEAR);

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state      <= IDLE;
         tap_count  <= '0;
         coeff_cnt  <= '0;
         wait_cnt   <= '0;
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cfg_error  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cfg_start) begin
            if (cfg_ok) begin
               tap_count <= cfg_tap_count;
               cfg_error <= 1'b0;
            end else begin
               cfg_error <= 1'b1;
            end
         end
         if (output_data_valid && !push_ok) cfg_error <= 1'b1;

         if (state == CLEAR)  coeff_cnt <= '0;
         else if (coeff_hs)   coeff_cnt <= (state_nxt == RUN) ? 32'd0 : coeff_cnt + 32'd1;

         if (data_hs && LATENCY > 1) wait_cnt <= WW'(LATENCY + 1);
         else if (wait_cnt != '0)    wait_cnt <= wait_cnt - WW'(1);

         // A sample stays in flight until the datapath returns its result.
         case ({data_hs, output_data_valid && inflight != '0})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase

         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push_ok) fifo_count <= fifo_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) fifo_mem[wr_ptr] <= output_data;
   end

endmodule

// File: tb/tb_fir_control_unit.sv
// Directed bench: instance 0 (LATENCY=1) carries most checks, instance 1 (LATENCY=3)
// shares the inputs and is checked for sample pacing. Datapath returns sample+100.
module tb_fir_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cfg_tap_count;
   logic        cfg_start, cfg_stop;
   logic        s_coeff_tvalid;
   logic [31:0] s_coeff_tdata;
   logic        s_data_tvalid;
   logic [31:0] s_data_tdata;
   logic        m_out_tready;

   logic        busy [2];
   logic        err [2];
   logic        coeff_rdy [2];
   logic        data_rdy [2];
   logic        out_vld [2];
   logic [31:0] out_data [2];
   logic        frstn [2];
   logic [31:0] tap [2];
   logic        ivld [2];
   logic [31:0] idata [2];
   logic        cvld [2];
   logic [31:0] cdata [2];
   logic        cmp [2];
   logic        dp_vld [2];
   logic [31:0] dp_data [2];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [2:0]  pv;
      logic [31:0] pd [3];

      fir_control_unit #(.MAX_TAPS(16), .LATENCY(g == 0 ? 1 : 3), .OUT_DEPTH(4)) u_dut (
         .clk(clk), .rst(rst),
         .cfg_tap_count(cfg_tap_count), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
         .cfg_busy(busy[g]), .cfg_error(err[g]),
         .s_coeff_tvalid(s_coeff_tvalid), .s_coeff_tready(coeff_rdy[g]), .s_coeff_tdata(s_coeff_tdata),
         .s_data_tvalid(s_data_tvalid), .s_data_tready(data_rdy[g]), .s_data_tdata(s_data_tdata),
         .m_out_tvalid(out_vld[g]), .m_out_tready(m_out_tready), .m_out_tdata(out_data[g]),
         .fir_rstn(frstn[g]), .tap_count(tap[g]),
         .input_data_valid(ivld[g]), .input_data(idata[g]),
         .coeff_data_valid(cvld[g]), .coeff_data(cdata[g]), .compute(cmp[g]),
         .output_data(dp_data[g]), .output_data_valid(dp_vld[g]),
         .coefficient_loading_complete(1'b0)
      );

      always_ff @(posedge clk) begin
         if (!frstn[g]) pv <= '0;
         else           pv <= {pv[1:0], ivld[g]};
         pd[0] <= idata[g] + 32'd100;
         pd[1] <= pd[0];
         pd[2] <= pd[1];
      end
      assign dp_vld[g]  = (g == 0) ? pv[0] : pv[2];
      assign dp_data[g] = (g == 0) ? pd[0] : pd[2];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      s_data_tvalid = 1'b1;
      s_data_tdata  = d;
      #1;
      while (!data_rdy[0] && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("send_hs", 32'(data_rdy[0]), 1);
      @(negedge clk);
      s_data_tvalid = 1'b0;
      #1;
   endtask

   task automatic quick_cfg(input int ntap);
      @(negedge clk);
      cfg_tap_count = ntap;
      cfg_start     = 1'b1;
      @(negedge clk);
      cfg_start      = 1'b0;
      s_coeff_tvalid = 1'b1;
      for (int k = 0; k < ntap; k++) begin
         @(negedge clk);
         s_coeff_tdata = k + 1;
      end
      @(negedge clk);
      s_coeff_tvalid = 1'b0;
      #1;
      chk("qc_run", 32'(data_rdy[0]), 1);
      chk("qc_tap", tap[0], ntap);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, last, nhs;
      rst = 1'b1; cfg_tap_count = '0; cfg_start = 1'b0; cfg_stop = 1'b0;
      s_coeff_tvalid = 1'b0; s_coeff_tdata = '0; s_data_tvalid = 1'b0; s_data_tdata = '0;
      m_out_tready = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_err", 32'(err[0]), 0);
      chk("rst_frstn", 32'(frstn[0]), 0);
      chk("rst_ovld", 32'(out_vld[0]), 0);
      chk("rst_crdy", 32'(coeff_rdy[0]), 0);
      chk("rst_drdy", 32'(data_rdy[0]), 0);
      chk("rst_tap", tap[0], 0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rel_frstn", 32'(frstn[0]), 1);

      // bad tap counts
      cfg_tap_count = 0; cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0; #1;
      chk("bad0_err", 32'(err[0]), 1);
      chk("bad0_busy", 32'(busy[0]), 0);
      chk("bad0_crdy", 32'(coeff_rdy[0]), 0);
      cfg_tap_count = 17; cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0; #1;
      chk("bad17_err", 32'(err[0]), 1);
      chk("bad17_busy", 32'(busy[0]), 0);
      chk("bad17_tap", tap[0], 0);

      // good start, coefficients 1..4 back to back
      cfg_tap_count = 4; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; s_coeff_tvalid = 1'b1; s_coeff_tdata = 1; #1;
      chk("cl_frstn", 32'(frstn[0]), 0);
      chk("cl_busy", 32'(busy[0]), 1);
      chk("cl_err", 32'(err[0]), 0);
      chk("cl_cvld", 32'(cvld[0]), 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         s_coeff_tdata = k; #1;
         chk("ld_frstn", 32'(frstn[0]), 1);
         chk("ld_cvld", 32'(cvld[0]), 1);
         chk("ld_cdata", cdata[0], k);
      end
      @(negedge clk);
      s_coeff_tvalid = 1'b0; #1;
      chk("run_crdy", 32'(coeff_rdy[0]), 0);
      chk("run_drdy", 32'(data_rdy[0]), 1);
      chk("run_tap", tap[0], 4);

      // start while running is ignored
      cfg_tap_count = 7; cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0; #1;
      chk("ign_tap", tap[0], 4);
      chk("ign_busy", 32'(busy[0]), 1);

      // credit stall with the output blocked
      m_out_tready = 1'b0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         s_data_tvalid = 1'b1; s_data_tdata = acc + 1; #1;
         chk("st_cmp", 32'(cmp[0]), 32'(ivld[0]));
         if (data_rdy[0]) begin
            chk("st_idata", idata[0], acc + 1);
            acc++;
         end
      end
      @(negedge clk);
      s_data_tvalid = 1'b0; #1;
      chk("st_acc", acc, 4);
      chk("st_ovld", 32'(out_vld[0]), 1);
      chk("st_head", out_data[0], 101);
      chk("st_err", 32'(err[0]), 0);
      chk("st_drdy", 32'(data_rdy[0]), 0);

      // release and collect in order
      m_out_tready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("dr_vld", 32'(out_vld[0]), 1);
         chk("dr_data", out_data[0], 100 + k);
         @(negedge clk); #1;
      end
      chk("dr_empty", 32'(out_vld[0]), 0);

      // stop with two results queued
      m_out_tready = 1'b0;
      send(5);
      send(6);
      @(negedge clk); @(negedge clk); #1;
      chk("q_vld", 32'(out_vld[0]), 1);
      cfg_stop = 1'b1; m_out_tready = 1'b1; #1;
      chk("sp_drdy", 32'(data_rdy[0]), 0);
      chk("sp_data", out_data[0], 105);
      @(negedge clk); cfg_stop = 1'b0; #1;
      chk("dn_busy", 32'(busy[0]), 1);
      chk("dn_drdy", 32'(data_rdy[0]), 0);
      chk("dn_data", out_data[0], 106);
      @(negedge clk); #1;
      chk("dn_empty", 32'(out_vld[0]), 0);
      chk("dn_busy2", 32'(busy[0]), 1);
      @(negedge clk); #1;
      chk("dn_idle", 32'(busy[0]), 0);
      m_out_tready = 1'b0;

      // maximum tap count, then reset mid-run with results queued
      quick_cfg(16);
      send(7);
      send(8);
      @(negedge clk); @(negedge clk); #1;
      chk("pr_vld", 32'(out_vld[0]), 1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rs_ovld", 32'(out_vld[0]), 0);
      chk("rs_odata", out_data[0], 0);
      chk("rs_frstn", 32'(frstn[0]), 0);
      chk("rs_busy", 32'(busy[0]), 0);
      chk("rs_tap", tap[0], 0);
      chk("rs_drdy", 32'(data_rdy[0]), 0);
      chk("rs_crdy", 32'(coeff_rdy[0]), 0);
      chk("rs_cmp", 32'(cmp[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rr_frstn", 32'(frstn[0]), 1);
      chk("rr_ovld", 32'(out_vld[0]), 0);

      // LATENCY=3 pacing on instance 1
      quick_cfg(2);
      chk("l3_busy", 32'(busy[1]), 1);
      m_out_tready = 1'b1;
      last = -1;
      nhs  = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         s_data_tvalid = 1'b1; s_data_tdata = c; #1;
         chk("l3_cmp", 32'(cmp[1]), 32'(ivld[1]));
         if (ivld[1]) begin
            if (last >= 0) chk("l3_gap", 32'((c - last) >= 4), 1);
            last = c;
            nhs++;
         end
      end
      @(negedge clk);
      s_data_tvalid = 1'b0; #1;
      chk("l3_nhs", 32'(nhs >= 3), 1);
      chk("l3_err", 32'(err[1]), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
